multi_code_lock: RTL

Parametrised successor to the board-level digital lock. It takes KEY_WIDTH active-low pushbuttons and synchronises them internally. It accepts a CODE_LEN-digit code whose digits are key indices, and counts failed attempts, entering a timed lockout after MAX_FAILS consecutive failures. While unlocked, the user can reprogram the code. It replaces the fixed-width lock FSM plus synchroniser at the top of the lock design; seven-segment decode stays outside and is driven from `last_key`.

---
 rtl/multi_code_lock.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multi_code_lock.sv
// Parametrised pushbutton code lock: key synchroniser, single-press detector,
// entry/unlock/reprogram FSM with failure counting and a timed lockout.
module multi_code_lock #(
    parameter int KEY_WIDTH      = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*$clog2(KEY_WIDTH)-1:0] DEFAULT_CODE = 8'h39,
    parameter int SYNC_LEN       = 2,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [KEY_WIDTH-1:0]                KEY,
    output logic                                LOCKED,
    output logic                                ERROR,
    output logic                                LOCKOUT,
    output logic [$clog2(CODE_LEN+1)-1:0]       digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count,
    output logic [$clog2(KEY_WIDTH)-1:0]        last_key
);

    localparam int KW = $clog2(KEY_WIDTH);
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_ENTRY,
        S_UNLOCKED,
        S_PROGRAM,
        S_ERROR,
        S_LOCKOUT
    } state_t;

    state_t                   state;
    logic [KEY_WIDTH-1:0]     sync_q [SYNC_LEN];
    logic [SYNC_LEN-1:0]      valid_q;
    logic [KEY_WIDTH-1:0]     prev;
    logic [CODE_LEN*KW-1:0]   code_q;
    logic [CODE_LEN*KW-1:0]   shadow_q;
    logic                     mismatch;
    logic [TW-1:0]            timer;

    logic [KEY_WIDTH-1:0]     synced;
    logic [KEY_WIDTH-1:0]     low;
    logic                     press;
    logic [KW-1:0]            idx;
    logic [IW-1:0]            ptr;
    logic [KW-1:0]            code_digit;
    logic [CODE_LEN*KW-1:0]   shadow_next;
    logic                     last_digit;
    logic                     miss_next;
    logic [FW-1:0]            fails_inc;

    // {LOCKED, ERROR, LOCKOUT} for a given state
    function automatic logic [2:0] flags_of(input state_t s);
        case (s)
            S_UNLOCKED, S_PROGRAM: flags_of = 3'b000;
            S_ERROR:               flags_of = 3'b110;
            S_LOCKOUT:             flags_of = 3'b111;
            default:               flags_of = 3'b100;
        endcase
    endfunction

    // valid_q marks when the chain holds real samples; until then prev stays
    // all-zeros so a key held through reset cannot look like a fresh press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_LEN; i++) sync_q[i] <= '1;
            valid_q <= '0;
            prev    <= '0;
        end else begin
            sync_q[0] <= KEY;
            for (int unsigned i = 1; i < SYNC_LEN; i++) sync_q[i] <= sync_q[i-1];
            valid_q <= {valid_q[SYNC_LEN-2:0], 1'b1};
            if (valid_q[SYNC_LEN-1]) prev <= synced;
        end
    end

    always_comb begin
        synced = sync_q[SYNC_LEN-1];
        low    = ~synced;
        press  = (&prev) && (low != '0) && ((low & (low - KEY_WIDTH'(1))) == '0);
        idx    = '0;
        for (int unsigned i = 0; i < KEY_WIDTH; i++)
            if (low[i]) idx = KW'(i);
    end

    always_comb begin
        ptr         = digit_count[IW-1:0];
        code_digit  = '0;
        shadow_next = shadow_q;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (ptr == IW'(i)) begin
                code_digit                = code_q[i*KW +: KW];
                shadow_next[i*KW +: KW]   = idx;
            end
        end
        last_digit = (digit_count == CW'(CODE_LEN - 1));
        miss_next  = mismatch | (idx != code_digit);
        fails_inc  = fail_count + FW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state                    <= S_ENTRY;
            {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ENTRY);
            code_q                   <= DEFAULT_CODE;
            shadow_q                 <= DEFAULT_CODE;
            digit_count              <= '0;
            fail_count               <= '0;
            mismatch                 <= 1'b0;
            timer                    <= '0;
            last_key                 <= '0;
        end else begin
            if (press) last_key <= idx;
            case (state)
                S_ENTRY: if (press) begin
                    if (last_digit) begin
                        digit_count <= '0;
                        mismatch    <= 1'b0;
                        if (!miss_next) begin
                            state                    <= S_UNLOCKED;
                            {LOCKED, ERROR, LOCKOUT} <= flags_of(S_UNLOCKED);
                            fail_count               <= '0;
                        end else begin
                            fail_count <= fails_inc;
                            if (fails_inc == FW'(MAX_FAILS)) begin
                                state                    <= S_LOCKOUT;
                                {LOCKED, ERROR, LOCKOUT} <= flags_of(S_LOCKOUT);
                                timer                    <= '0;
                            end else begin
                                state                    <= S_ERROR;
                                {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ERROR);
                            end
                        end
                    end else begin
                        digit_count <= digit_count + CW'(1);
                        mismatch    <= miss_next;
                    end
                end
                S_ERROR: if (press) begin
                    state                    <= S_ENTRY;
                    {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ENTRY);
                end
                S_LOCKOUT: begin
                    if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
                        state                    <= S_ENTRY;
                        {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ENTRY);
                        fail_count               <= '0;
                        timer                    <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_UNLOCKED: if (press) begin
                    if (idx == '0) begin
                        state                    <= S_ENTRY;
                        {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ENTRY);
                    end else if (idx == KW'(KEY_WIDTH - 1)) begin
                        state                    <= S_PROGRAM;
                        {LOCKED, ERROR, LOCKOUT} <= flags_of(S_PROGRAM);
                        digit_count              <= '0;
                    end
                end
                S_PROGRAM: if (press) begin
                    shadow_q <= shadow_next;
                    if (last_digit) begin
                        code_q                   <= shadow_next;
                        digit_count              <= '0;
                        state                    <= S_ENTRY;
                        {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ENTRY);
                    end else begin
                        digit_count <= digit_count + CW'(1);
                    end
                end
                default: begin
                    state                    <= S_ENTRY;
                    {LOCKED, ERROR, LOCKOUT} <= flags_of(S_ENTRY);
                end
            endcase
        end
    end

endmodule
